// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock synchronous FIFO with registered read data,
// occupancy count and sticky overflow/underflow flags.
// Ports:
//   clk            - clock, all state updates on rising edge
//   rst            - asynchronous active-high reset
//   fifo_write     - write request
//   fifo_read      - read request
//   fifo_data_in   - write data
//   fifo_data_out  - registered read data (one-clock latency)
//   fifo_full      - cnt == fifo_depth (combinational decode)
//   fifo_empty     - cnt == 0 (combinational decode)
//   fifo_count     - current occupancy
//   fifo_overflow  - sticky: write attempted while full without a read
//   fifo_underflow - sticky: read attempted while empty
module fifo_buffer #(
   parameter int unsigned fifo_depth = 8,
   parameter int unsigned fifo_width = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_write,
   input  logic                         fifo_read,
   input  logic [fifo_width-1:0]        fifo_data_in,
   output logic [fifo_width-1:0]        fifo_data_out,
   output logic                         fifo_full,
   output logic                         fifo_empty,
   output logic [$clog2(fifo_depth):0]  fifo_count,
   output logic                         fifo_overflow,
   output logic                         fifo_underflow
);

   localparam int unsigned ptr_w = $clog2(fifo_depth);
   localparam int unsigned cnt_w = ptr_w + 1;

   logic [fifo_width-1:0] mem [fifo_depth];
   logic [ptr_w-1:0]      wr_ptr;
   logic [ptr_w-1:0]      rd_ptr;
   logic [cnt_w-1:0]      cnt;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status decodes of the occupancy counter
   assign fifo_full  = (cnt == cnt_w'(fifo_depth));
   assign fifo_empty = (cnt == '0);
   assign fifo_count = cnt;

   // A write into a full FIFO is only accepted when a read frees a slot
   assign wr_acc = fifo_write && (!fifo_full || fifo_read);
   assign rd_acc = fifo_read && !fifo_empty;

   // Storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= fifo_data_in;
      end
   end

   // Pointers, counter, read data and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         cnt            <= '0;
         fifo_data_out  <= '0;
         fifo_overflow  <= 1'b0;
         fifo_underflow <= 1'b0;
      end else begin
         // Power-of-two depth: natural pointer rollover gives the modulo wrap
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ptr_w'(1);
         end
         if (rd_acc) begin
            rd_ptr        <= rd_ptr + ptr_w'(1);
            fifo_data_out <= mem[rd_ptr];
         end
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + cnt_w'(1);
            2'b01:   cnt <= cnt - cnt_w'(1);
            default: cnt <= cnt;
         endcase
         if (fifo_write && fifo_full && !fifo_read) begin
            fifo_overflow <= 1'b1;
         end
         if (fifo_read && fifo_empty) begin
            fifo_underflow <= 1'b1;
         end
      end
   end

endmodule
